// File: rtl/lfsr_enc_pkg.sv
// Shared types and constants for the LFSR cipher: FSM states, the tap-pattern table
// (common with the decryptor) and the preamble clamp bounds.
package lfsr_enc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLdPre,
        StLdTap,
        StLdSeed,
        StEnc,
        StDone
    } state_e;

    localparam int unsigned NumPtrn = 6;

    localparam logic [4:0] LFSR_PTRN [NumPtrn] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};

    localparam logic [5:0] PRE_MIN = 6'd7;
    localparam logic [5:0] PRE_MAX = 6'd12;

    // Out-of-range tap indices fall back to pattern 0.
    function automatic logic [4:0] tap_pattern(input logic [2:0] idx);
        logic [2:0] sel;
        sel = (idx > 3'd5) ? 3'd0 : idx;
        return LFSR_PTRN[sel];
    endfunction

endpackage

// File: rtl/lfsr_encryptor_if.sv
// Start/status handshake plus the dat_mem read/write port of the LFSR encryptor.
// The master modport is the encryptor; the slave side is the host and data memory.
interface lfsr_encryptor_if;
    logic       init;
    logic [7:0] raddr;
    logic [7:0] data_out;
    logic [7:0] waddr;
    logic [7:0] data_in;
    logic       wr_en;
    logic       busy;
    logic       done;

    modport master (
        input  init,
        input  data_out,
        output raddr,
        output waddr,
        output data_in,
        output wr_en,
        output busy,
        output done
    );

    modport slave (
        output init,
        output data_out,
        input  raddr,
        input  waddr,
        input  data_in,
        input  wr_en,
        input  busy,
        input  done
    );
endinterface

// File: rtl/lfsr5.sv
// 5-bit Fibonacci-style LFSR with selectable taps: load on init_i, shift left on en_i
// with the parity of (state & taps) entering at bit 0.
module lfsr5 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       init_i,
    input  logic [4:0] taps_i,
    input  logic [4:0] start_i,
    output logic [4:0] state_o
);

    logic [4:0] state_q;
    logic [4:0] state_d;

    always_comb begin
        state_d = state_q;
        if (init_i) begin
            state_d = start_i;
        end else if (en_i) begin
            state_d = {state_q[3:0], ^(state_q & taps_i)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 5'h00;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_encryptor.sv
// LFSR cipher encryptor: loads preamble length, tap index and seed from memory, then
// writes CT_LEN ciphertext bytes. Define LFSR_ENC_PRE_CLAMP_EN to clamp the preamble to 7..12.
module lfsr_encryptor
    import lfsr_enc_pkg::*;
#(
    parameter logic [7:0]  MSG_ADDR  = 8'd0,
    parameter logic [7:0]  CT_ADDR   = 8'd64,
    parameter logic [7:0]  PRE_ADDR  = 8'd61,
    parameter logic [7:0]  TAP_ADDR  = 8'd62,
    parameter logic [7:0]  SEED_ADDR = 8'd63,
    parameter int unsigned CT_LEN    = 64,
    parameter logic [7:0]  PRE_CHAR  = 8'h5F
) (
    input logic               clk,
    input logic               rst_n,
    lfsr_encryptor_if.master  bus
);

    localparam logic [7:0] LastK = 8'(CT_LEN - 1);

    state_e     state_q;
    logic [5:0] pre_q;
    logic [2:0] tap_q;
    logic [7:0] k_q;
    logic [7:0] waddr_q;
    logic       wr_en_q;
    logic       busy_q;
    logic       done_q;

    logic [5:0] pre_d;
    logic [4:0] seed_d;
    logic [4:0] taps;
    logic [4:0] lfsr_state;
    logic [7:0] msg_off;
    logic [7:0] raddr_c;
    logic [7:0] data_in_c;

    always_comb begin
`ifdef LFSR_ENC_PRE_CLAMP_EN
        if (bus.data_out[5:0] < PRE_MIN) begin
            pre_d = PRE_MIN;
        end else if (bus.data_out[5:0] > PRE_MAX) begin
            pre_d = PRE_MAX;
        end else begin
            pre_d = bus.data_out[5:0];
        end
`else
        pre_d = bus.data_out[5:0];
`endif
    end

    // An all-zero seed would lock the LFSR at zero.
    assign seed_d = (bus.data_out[4:0] == 5'h00) ? 5'h01 : bus.data_out[4:0];
    assign taps   = tap_pattern(tap_q);

    lfsr5 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == StEnc),
        .init_i  (state_q == StLdSeed),
        .taps_i  (taps),
        .start_i (seed_d),
        .state_o (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pre_q   <= 6'd0;
            tap_q   <= 3'd0;
            k_q     <= 8'd0;
            waddr_q <= 8'd0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (bus.init) begin
                        state_q <= StLdPre;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StLdPre: begin
                    pre_q   <= pre_d;
                    state_q <= StLdTap;
                end
                StLdTap: begin
                    tap_q   <= bus.data_out[2:0];
                    state_q <= StLdSeed;
                end
                StLdSeed: begin
                    k_q     <= 8'd0;
                    waddr_q <= CT_ADDR;
                    wr_en_q <= 1'b1;
                    state_q <= StEnc;
                end
                StEnc: begin
                    k_q     <= k_q + 8'd1;
                    waddr_q <= waddr_q + 8'd1;
                    if (k_q == LastK) begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign msg_off = k_q - {2'b00, pre_q};

    // Read address and write data are decoded from registered state only.
    always_comb begin
        raddr_c   = 8'd0;
        data_in_c = 8'd0;
        case (state_q)
            StLdPre:  raddr_c = PRE_ADDR;
            StLdTap:  raddr_c = TAP_ADDR;
            StLdSeed: raddr_c = SEED_ADDR;
            StEnc: begin
                raddr_c   = MSG_ADDR + msg_off;
                data_in_c = ((k_q < {2'b00, pre_q}) ? PRE_CHAR : bus.data_out)
                            ^ {3'b000, lfsr_state};
            end
            default: ;
        endcase
    end

    assign bus.raddr   = raddr_c;
    assign bus.data_in = data_in_c;
    assign bus.waddr   = waddr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_lfsr_encryptor.sv
// Directed bench for lfsr_encryptor: table of configurations with hand-computed ciphertext
// bytes, plus sequences for mid-block reset, ignored init and restart from DONE.
module tb_lfsr_encryptor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lfsr_encryptor_if bus ();

    lfsr_encryptor u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rom  [64];
    logic [7:0] ct   [64];
    logic [7:0] gold [64];
    int         wr_count = 0;

    assign bus.data_out = (bus.raddr < 8'd64) ? rom[bus.raddr[5:0]] : 8'h00;

    always @(posedge clk) begin
        if (bus.wr_en) begin
            if (bus.waddr >= 8'd64 && bus.waddr < 8'd128) ct[bus.waddr[5:0]] <= bus.data_in;
            wr_count <= wr_count + 1;
        end
    end

    typedef struct packed {
        logic [7:0]       pre;
        logic [7:0]       tap;
        logic [7:0]       seed;
        logic [3:0][7:0]  addr;
        logic [3:0][7:0]  exp;
    } vec_t;

    localparam int NumVec = 8;
    vec_t vecs [NumVec];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] pre, input logic [7:0] tap, input logic [7:0] seed);
        rom[61] = pre;
        rom[62] = tap;
        rom[63] = seed;
    endtask

    // Start a block and wait for done; cycle 1 is the one after the edge that samples init.
    task automatic run_block(input int pulse_at, output int cyc_done, output int nwr,
                             output logic done_first);
        int w0;
        cyc_done   = -1;
        done_first = 1'bx;
        @(negedge clk);
        bus.init = 1'b1;
        @(posedge clk);
        w0 = wr_count;
        #1;
        bus.init = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c == 1) done_first = bus.done;
            bus.init = (c == pulse_at);
            if (bus.done) begin
                cyc_done = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.init = 1'b0;
        nwr = wr_count - w0;
    endtask

    function automatic int count_diff();
        int bad = 0;
        for (int j = 0; j < 64; j++) if (ct[j] !== gold[j]) bad++;
        return bad;
    endfunction

    initial begin
        int   cd;
        int   nw;
        int   w0;
        logic df;

        rst_n    = 1'b0;
        bus.init = 1'b0;
        rom[0] = 8'h48; rom[1] = 8'h65; rom[2] = 8'h6C; rom[3] = 8'h6C; rom[4] = 8'h6F;
        for (int j = 5; j < 61; j++) rom[j] = 8'h30 + 8'(j);
        set_cfg(8'h07, 8'h00, 8'h01);

        // Seed 01 with taps 1E runs 01 02 05 0B 16 0D 1A 15 0A 14 08 11 03 ...
        vecs[0] = '{pre: 8'h07, tap: 8'h00, seed: 8'h01,
                    addr: {8'd64, 8'd65, 8'd66, 8'd71}, exp: {8'h5E, 8'h5D, 8'h5A, 8'h5D}};
        vecs[1] = '{pre: 8'h08, tap: 8'h00, seed: 8'h01,
                    addr: {8'd71, 8'd72, 8'd73, 8'd74}, exp: {8'h4A, 8'h42, 8'h71, 8'h64}};
        vecs[2] = '{pre: 8'h07, tap: 8'h07, seed: 8'hE0,
                    addr: {8'd64, 8'd65, 8'd66, 8'd71}, exp: {8'h5E, 8'h5D, 8'h5A, 8'h5D}};
        vecs[4] = '{pre: 8'hC7, tap: 8'hFD, seed: 8'hFF,
                    addr: {8'd64, 8'd65, 8'd66, 8'd67}, exp: {8'h40, 8'h41, 8'h43, 8'h46}};
        vecs[5] = '{pre: 8'h07, tap: 8'h01, seed: 8'h01,
                    addr: {8'd64, 8'd65, 8'd66, 8'd67}, exp: {8'h5E, 8'h5C, 8'h58, 8'h51}};
`ifdef LFSR_ENC_PRE_CLAMP_EN
        vecs[3] = '{pre: 8'h03, tap: 8'h00, seed: 8'h01,
                    addr: {8'd66, 8'd67, 8'd68, 8'd70}, exp: {8'h5A, 8'h54, 8'h49, 8'h45}};
        vecs[6] = '{pre: 8'h00, tap: 8'h00, seed: 8'h01,
                    addr: {8'd64, 8'd65, 8'd66, 8'd67}, exp: {8'h5E, 8'h5D, 8'h5A, 8'h54}};
        vecs[7] = '{pre: 8'h3F, tap: 8'h00, seed: 8'h01,
                    addr: {8'd64, 8'd65, 8'd75, 8'd76}, exp: {8'h5E, 8'h5D, 8'h4E, 8'h4B}};
`else
        vecs[3] = '{pre: 8'h03, tap: 8'h00, seed: 8'h01,
                    addr: {8'd66, 8'd67, 8'd68, 8'd70}, exp: {8'h5A, 8'h43, 8'h73, 8'h76}};
        vecs[6] = '{pre: 8'h00, tap: 8'h00, seed: 8'h01,
                    addr: {8'd64, 8'd65, 8'd66, 8'd67}, exp: {8'h49, 8'h67, 8'h69, 8'h67}};
        vecs[7] = '{pre: 8'h3F, tap: 8'h00, seed: 8'h01,
                    addr: {8'd64, 8'd65, 8'd75, 8'd76}, exp: {8'h5E, 8'h5D, 8'h4E, 8'h5C}};
`endif

        #12;
        check("reset wr_en", {31'b0, bus.wr_en}, 32'd0);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset raddr", {24'b0, bus.raddr}, 32'd0);
        check("reset waddr", {24'b0, bus.waddr}, 32'd0);
        check("reset data_in", {24'b0, bus.data_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            set_cfg(vecs[i].pre, vecs[i].tap, vecs[i].seed);
            run_block(0, cd, nw, df);
            check($sformatf("v%0d done cycle", i), cd, 68);
            check($sformatf("v%0d write count", i), nw, 64);
            for (int j = 0; j < 4; j++) begin
                check($sformatf("v%0d ct[%0d]", i, vecs[i].addr[j]),
                      {24'b0, ct[vecs[i].addr[j][5:0]]}, {24'b0, vecs[i].exp[j]});
            end
            if (i == 0) for (int j = 0; j < 64; j++) gold[j] = ct[j];
        end

        // Reset in the middle of ENC, then a clean rerun of the reference block.
        set_cfg(8'h07, 8'h00, 8'h01);
        @(negedge clk);
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        check("pre-reset wr_en", {31'b0, bus.wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset mid wr_en", {31'b0, bus.wr_en}, 32'd0);
        check("reset mid done", {31'b0, bus.done}, 32'd0);
        check("reset mid busy", {31'b0, bus.busy}, 32'd0);
        w0 = wr_count;
        repeat (3) @(posedge clk);
        #1;
        check("writes in reset", wr_count - w0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle after reset", {30'b0, bus.busy, bus.wr_en}, 32'd0);
        run_block(0, cd, nw, df);
        check("rerun done cycle", cd, 68);
        check("rerun write count", nw, 64);
        check("rerun block diffs", count_diff(), 0);

        // init while busy is ignored.
        run_block(10, cd, nw, df);
        check("busy-init done cycle", cd, 68);
        check("busy-init write count", nw, 64);
        check("busy-init block diffs", count_diff(), 0);

        // Restart straight out of DONE.
        check("done held", {31'b0, bus.done}, 32'd1);
        run_block(0, cd, nw, df);
        check("restart done falls", {31'b0, df}, 32'd0);
        check("restart done cycle", cd, 68);
        check("restart write count", nw, 64);
        check("restart block diffs", count_diff(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_encryptor.md
# lfsr_encryptor

Encryption engine for the lab-5 LFSR cipher: the transmit-side counterpart of the 6-LFSR decryptor. On `init` it reads a preamble length, tap-pattern index and LFSR seed from data memory. It then writes a fixed-length ciphertext block, consisting of the encrypted preamble characters followed by the encrypted plaintext, back to data memory through the standard `dat_mem` port set. Its output is exactly the memory image the decryptor consumes.

## Interface
Parameters:
- `MSG_ADDR`, 8'd0: first plaintext byte address
- `CT_ADDR`, 8'd64: first ciphertext byte address
- `PRE_ADDR`, 8'd61: preamble-length control byte
- `TAP_ADDR`, 8'd62: tap-index control byte
- `SEED_ADDR`, 8'd63: LFSR seed control byte
- `CT_LEN`, 64: ciphertext bytes written, preamble included
- `PRE_CHAR`, 8'h5F: preamble character (`_`)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `init`  in  1  start request, sampled on `clk`
- `raddr`  out  8  memory read address
- `data_out`  in  8  memory read data, combinational from `raddr`
- `waddr`  out  8  memory write address
- `data_in`  out  8  memory write data
- `wr_en`  out  1  memory write enable
- `busy`  out  1  encryption in progress
- `done`  out  1  block complete; held until next start

## Operation
- FSM states: IDLE, LD_PRE, LD_TAP, LD_SEED, ENC, DONE.
- IDLE or DONE, with `init`=1 at an edge: go to LD_PRE.
- LD_PRE:
  - `raddr`=`PRE_ADDR`; latch P = `data_out[5:0]`, clamped per Configuration.
  - Go to LD_TAP.
- LD_TAP:
  - `raddr`=`TAP_ADDR`; latch tap index t = `data_out[2:0]`; t>5 is treated as 0.
  - Go to LD_SEED.
- LD_SEED:
  - `raddr`=`SEED_ADDR`; load LFSR with `data_out[4:0]`. A zero seed is replaced by 5'h01.
  - Clear position counter k. Go to ENC.
- ENC, one byte per cycle, k = 0..`CT_LEN`-1:
  - Plain byte p = `PRE_CHAR` if k<P, else memory at `MSG_ADDR`+(k-P), driven on `raddr`.
  - Outputs: `wr_en`=1, `waddr`=`CT_ADDR`+k, `data_in` = p ^ {3'b000, state}.
  - On the edge: LFSR advances and k increments.
  - After k=`CT_LEN`-1, go to DONE.
- DONE: `done`=1, no writes. Leave only on `init` (restart).
- LFSR step: state ← {state[3:0], ^(state & taps)}. taps = LFSR_PTRN[t], where LFSR_PTRN = {1E,1D,1B,17,14,12}. The first byte uses the seed state unadvanced.
- Address arithmetic is 8-bit and wraps modulo 256.
- If P ≥ `CT_LEN`, every written byte is preamble.

## Timing
- Reset values: state IDLE; `wr_en`=0, `busy`=0, `done`=0; `raddr`=0, `waddr`=0, `data_in`=0; LFSR=0; k=0.
- Outputs decode from state and registers only. Asserting `rst_n` therefore drops `wr_en` immediately, including mid-ENC. No partial write follows release.
- Cycle map, with cycle 0 being the edge that samples `init`:
  - Cycles 1–3: LD_PRE, LD_TAP, LD_SEED.
  - Cycles 4..3+`CT_LEN`: ENC writes.
  - Cycle 4+`CT_LEN` onward (68 at default): `done`=1.
- `busy`=1 in LD_PRE through ENC.
- `init` is ignored while `busy`=1.
- `init` held high in DONE restarts; `done` falls the next cycle.

## Configuration
- `LFSR_ENC_PRE_CLAMP_EN` defined: P is clamped to [7,12]. Values below 7 become 7; values above 12 become 12.
- Not defined: P = `data_out[5:0]` verbatim (0..63). P=0 means no preamble.

## Structure
- Package `lfsr_enc_pkg` holds:
  - the state enum;
  - the LFSR_PTRN[6] constant table;
  - the PRE_MIN/PRE_MAX constants (7/12).
- Shares the tap table with the decryptor.
- Sub-module: reuse `lfsr5` for the LFSR.
  - `en` = in ENC.
  - `init` = in LD_SEED.
  - `taps` = LFSR_PTRN[t].
  - `start` = fixed-up seed.

## Test plan
- **Basic preamble encryption.** Seed 01, t=0 (1E), P=7. Expect mem[64..66] = 5E, 5D, 5A (states 01, 02, 05). Expect `done` at cycle 68.
- **Message encryption.** mem[0..2] = "Hel", P=8, any t/seed. Expect mem[72..74] = plaintext ^ {3'b0, s8..s10} per the software model. Expect exactly 64 `wr_en` pulses.
- **Zero seed and out-of-range tap.** Seed 00 with t=7. Output must be identical to seed 01, t=0.
- **Preamble clamp.** mem[61]=3.
  - With macro: mem[64..70] all encrypt 5F.
  - Without macro: mem[67] = mem[0] ^ {3'b0, s3}.
- **Reset mid-operation.** Drop `rst_n` at cycle 20. Expect `wr_en` and `done` at 0 in the same cycle. After release and `init`, a full correct 64-byte block is written.
- **Init handling.** `init` pulsed at cycle 10 has no effect. `init` in DONE restarts with identical output.
